// File: rtl/cc_jugabilidad_gen.sv
// ---------------------------------------------------------------------------
// cc_jugabilidad_gen
//
// Playability filter placed between the random row generator and the
// background shift registers. Each accepted load request either emits a
// "car row" (candidate row from the generator, with every channel
// guaranteed to contain a free run of at least MINGAP zero bits) or a
// blank row. SPACING blank rows follow every car row.
//
// Ports:
//   CC_JugabilidadGen_CLOCK_50          in   system clock
//   CC_JugabilidadGen_RESET_InLow       in   synchronous reset, active low
//   CC_JugabilidadGen_load_InLow        in   row request, active low level;
//                                            a falling edge is one request
//   CC_JugabilidadGen_data_InBUS        in   NCHAN*DATAWIDTH candidate rows
//   CC_JugabilidadGen_data_OutBUS       out  emitted row (0 when idle)
//   CC_JugabilidadGen_BackregsLoadInLow out  background load strobe, active
//                                            low, one cycle per emitted row
//   CC_JugabilidadGen_fixCount          out  count of rows needing a fix
//
// Optional feature: define CC_JUGABILIDAD_STATS_EN to build the saturating
// fixCount counter; otherwise fixCount is a constant zero.
// ---------------------------------------------------------------------------
module cc_jugabilidad_gen #(
    parameter int DATAWIDTH = 8,
    parameter int NCHAN     = 2,
    parameter int SPACING   = 1,
    parameter int MINGAP    = 2
) (
    input  logic                       CC_JugabilidadGen_CLOCK_50,
    input  logic                       CC_JugabilidadGen_RESET_InLow,
    input  logic                       CC_JugabilidadGen_load_InLow,
    input  logic [NCHAN*DATAWIDTH-1:0] CC_JugabilidadGen_data_InBUS,
    output logic [NCHAN*DATAWIDTH-1:0] CC_JugabilidadGen_data_OutBUS,
    output logic                       CC_JugabilidadGen_BackregsLoadInLow,
    output logic [15:0]                CC_JugabilidadGen_fixCount
);

    localparam int BUSW = NCHAN * DATAWIDTH;
    localparam int ROTW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    // Last legal start position of the cleared window.
    localparam logic [ROTW-1:0] ROT_MAX = ROTW'(DATAWIDTH - MINGAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_EMIT,
        S_BLANK
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      blank_cnt_reg, blank_cnt_next;
    logic [ROTW-1:0] rot_pos_reg, rot_pos_next;
    logic            load_prev_reg;
    logic [BUSW-1:0] out_reg, out_next;

    logic                 trig;
    logic [DATAWIDTH-1:0] clear_mask;
    logic [BUSW-1:0]      fixed_row;
    logic [NCHAN-1:0]     chan_fixed;
    logic                 any_fix;

    // A request is the falling edge of the level strobe, so holding it low
    // yields a single request.
    assign trig = load_prev_reg & ~CC_JugabilidadGen_load_InLow;

    // Window of MINGAP bits starting at rot_pos; shared by all channels so
    // every channel fixed in the same row opens the same gap.
    always_comb begin
        clear_mask = '0;
        for (int b = 0; b < DATAWIDTH; b++) begin
            if ((b >= int'(rot_pos_reg)) && (b < int'(rot_pos_reg) + MINGAP)) begin
                clear_mask[b] = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
        logic [DATAWIDTH-1:0] chan_row;
        logic                 needs_fix;

        assign chan_row = CC_JugabilidadGen_data_InBUS[gi*DATAWIDTH +: DATAWIDTH];

        // Longest run of zero bits anywhere in the channel row.
        always_comb begin
            int run_len;
            int best_len;
            run_len  = 0;
            best_len = 0;
            for (int b = 0; b < DATAWIDTH; b++) begin
                if (chan_row[b]) begin
                    run_len = 0;
                end else begin
                    run_len = run_len + 1;
                end
                if (run_len > best_len) begin
                    best_len = run_len;
                end
            end
            needs_fix = (best_len < MINGAP);
        end

        assign chan_fixed[gi] = needs_fix;
        assign fixed_row[gi*DATAWIDTH +: DATAWIDTH] =
            needs_fix ? (chan_row & ~clear_mask) : chan_row;
    end

    assign any_fix = |chan_fixed;

    always_ff @(posedge CC_JugabilidadGen_CLOCK_50) begin
        if (!CC_JugabilidadGen_RESET_InLow) begin
            state_reg     <= S_IDLE;
            blank_cnt_reg <= '0;
            rot_pos_reg   <= '0;
            load_prev_reg <= 1'b1;
            out_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            blank_cnt_reg <= blank_cnt_next;
            rot_pos_reg   <= rot_pos_next;
            load_prev_reg <= CC_JugabilidadGen_load_InLow;
            out_reg       <= out_next;
        end
    end

    always_comb begin
        state_next                          = state_reg;
        blank_cnt_next                      = blank_cnt_reg;
        rot_pos_next                        = rot_pos_reg;
        out_next                            = out_reg;
        CC_JugabilidadGen_data_OutBUS       = '0;
        CC_JugabilidadGen_BackregsLoadInLow = 1'b1;

        case (state_reg)
            S_IDLE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // Requests arriving in any other state are simply dropped.
                if (trig) begin
                    state_next = (blank_cnt_reg == 4'd0) ? S_CHECK : S_BLANK;
                end
            end
            S_CHECK: begin
                // The only cycle in which the input bus is sampled.
                out_next = fixed_row;
                if (any_fix) begin
                    rot_pos_next = (rot_pos_reg == ROT_MAX) ? '0 : rot_pos_reg + 1'b1;
                end
                state_next = S_EMIT;
            end
            S_EMIT: begin
                CC_JugabilidadGen_data_OutBUS       = out_reg;
                CC_JugabilidadGen_BackregsLoadInLow = 1'b0;
                blank_cnt_next                      = 4'(SPACING);
                state_next                          = S_WAIT;
            end
            S_BLANK: begin
                CC_JugabilidadGen_BackregsLoadInLow = 1'b0;
                blank_cnt_next                      = blank_cnt_reg - 1'b1;
                state_next                          = S_WAIT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef CC_JUGABILIDAD_STATS_EN
    logic [15:0] fix_count_reg;

    always_ff @(posedge CC_JugabilidadGen_CLOCK_50) begin
        if (!CC_JugabilidadGen_RESET_InLow) begin
            fix_count_reg <= '0;
        end else if ((state_reg == S_CHECK) && any_fix && (fix_count_reg != 16'hFFFF)) begin
            fix_count_reg <= fix_count_reg + 16'd1;
        end
    end

    assign CC_JugabilidadGen_fixCount = fix_count_reg;
`else
    assign CC_JugabilidadGen_fixCount = 16'h0000;
`endif

endmodule

// File: tb/tb_cc_jugabilidad_gen.sv
// ---------------------------------------------------------------------------
// Testbench for cc_jugabilidad_gen (default parameters). Inputs are driven
// and outputs sampled on the falling clock edge. A reference model derives
// every emitted row from the filter rules: longest zero run per channel,
// MINGAP-bit window cleared at the rotating position, SPACING blank rows
// after each car row.
// ---------------------------------------------------------------------------
module tb_cc_jugabilidad_gen;

    localparam int DW = 8;
    localparam int NC = 2;
    localparam int SP = 1;
    localparam int MG = 2;
    localparam int BW = DW * NC;

`ifdef CC_JUGABILIDAD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          load_n;
    logic [BW-1:0] data_in;
    logic [BW-1:0] dout;
    logic          strobe;
    logic [15:0]   fix_count;

    int n_checks;
    int n_fail;

    // Reference model state
    int m_rot;
    int m_blanks;
    int m_fix;

    cc_jugabilidad_gen #(
        .DATAWIDTH(DW),
        .NCHAN    (NC),
        .SPACING  (SP),
        .MINGAP   (MG)
    ) dut (
        .CC_JugabilidadGen_CLOCK_50         (clk),
        .CC_JugabilidadGen_RESET_InLow      (rst_n),
        .CC_JugabilidadGen_load_InLow       (load_n),
        .CC_JugabilidadGen_data_InBUS       (data_in),
        .CC_JugabilidadGen_data_OutBUS      (dout),
        .CC_JugabilidadGen_BackregsLoadInLow(strobe),
        .CC_JugabilidadGen_fixCount         (fix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Longest zero run of a channel value, then the filter rule.
    function automatic logic [BW-1:0] model_row(input logic [BW-1:0] row, input int rot,
                                                output bit any);
        int res;
        int ch;
        int run;
        int best;
        res = 0;
        any = 1'b0;
        for (int c = 0; c < NC; c++) begin
            ch   = (int'(row) >> (c * DW)) & ((1 << DW) - 1);
            run  = 0;
            best = 0;
            for (int b = 0; b < DW; b++) begin
                run  = ((ch >> b) & 1) ? 0 : run + 1;
                best = (run > best) ? run : best;
            end
            if (best < MG) begin
                ch  = ch & ~(((1 << MG) - 1) << rot);
                any = 1'b1;
            end
            res = res | ((ch & ((1 << DW) - 1)) << (c * DW));
        end
        return BW'(res);
    endfunction

    function automatic void model_reset();
        m_rot    = 0;
        m_blanks = 0;
        m_fix    = 0;
    endfunction

    // One request: drive a falling edge on load, present junk on the bus
    // except while the filter samples it, and check every cycle of the
    // window. retrig adds a second falling edge while the car row is
    // being emitted, which must be ignored.
    task automatic do_trigger(input logic [BW-1:0] row, input int low_len, input bit retrig,
                              output logic [BW-1:0] got);
        bit            exp_blank;
        bit            any;
        int            exp_idx;
        int            win;
        int            exp_fc;
        logic [BW-1:0] exp_row;
        any       = 1'b0;
        exp_blank = (m_blanks != 0);
        exp_idx   = exp_blank ? 1 : 2;
        exp_row   = '0;
        if (!exp_blank) exp_row = model_row(row, m_rot, any);
        win = (low_len + 4 < 6) ? 6 : low_len + 4;
        got = '0;

        @(negedge clk);
        load_n  = 1'b0;
        data_in = BW'($urandom);
        for (int i = 1; i <= win; i++) begin
            @(negedge clk);
            n_checks++;
            if (i == exp_idx) begin
                got = dout;
                if (strobe !== 1'b0 || dout !== exp_row) begin
                    n_fail++;
                    $display("FAIL emit: cycle %0d strobe=%b out=%h, required strobe=0 out=%h",
                             i, strobe, dout, exp_row);
                end
            end else if (strobe !== 1'b1 || dout !== '0) begin
                n_fail++;
                $display("FAIL idle: cycle %0d strobe=%b out=%h, required strobe=1 out=0000",
                         i, strobe, dout);
            end
            data_in = (i == 1) ? row : BW'($urandom);
            if (retrig) begin
                if (i == 1) load_n = 1'b1;
                else if (i == 2) load_n = 1'b0;
                else if (i == 3) load_n = 1'b1;
            end else if (i == low_len) begin
                load_n = 1'b1;
            end
        end

        if (exp_blank) begin
            m_blanks--;
        end else begin
            if (any) begin
                m_rot = (m_rot == DW - MG) ? 0 : m_rot + 1;
                if (m_fix < 16'hFFFF) m_fix++;
            end
            m_blanks = SP;
        end
        exp_fc = STATS ? m_fix : 0;
        n_checks++;
        if (fix_count !== 16'(exp_fc)) begin
            n_fail++;
            $display("FAIL fixcount: got %0d, required %0d", fix_count, exp_fc);
        end
        $display("trig in=%h %s out=%h rot_next=%0d", row, exp_blank ? "blank" : "car  ",
                 got, m_rot);
    endtask

    // Reset held for n cycles with load toggling; outputs checked during
    // reset and for the cycle after release.
    task automatic test_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            n_checks++;
            if (strobe !== 1'b1 || dout !== '0 || fix_count !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset: strobe=%b out=%h fc=%h, required 1/0000/0000",
                         strobe, dout, fix_count);
            end
            load_n  = ~load_n;
            data_in = BW'($urandom);
            if (i == n) begin
                rst_n  = 1'b1;
                load_n = 1'b1;
            end
        end
        model_reset();
        @(negedge clk);
        n_checks++;
        if (strobe !== 1'b1 || dout !== '0 || fix_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_release: strobe=%b out=%h fc=%h, required 1/0000/0000",
                     strobe, dout, fix_count);
        end
        @(negedge clk);
        $display("reset applied for %0d cycles", n);
    endtask

    task automatic test_basic();
        logic [BW-1:0] got;
        test_reset(3);
        do_trigger(16'h0FFF, 2, 1'b0, got);
        n_checks++;
        if (got !== 16'h0FFC) begin
            n_fail++;
            $display("FAIL basic_fix: got %h, required 0ffc", got);
        end
        for (int k = 0; k < 3; k++) do_trigger(16'hEE00, 1, 1'b0, got);
    endtask

    task automatic test_hold_low();
        logic [BW-1:0] got;
        do_trigger(16'h5A3C, 10, 1'b0, got);
        do_trigger(16'hFFFF, 10, 1'b0, got);
    endtask

    task automatic test_rotation();
        logic [BW-1:0] got;
        logic [7:0]    tab[8];
        tab = '{8'hFC, 8'hF9, 8'hF3, 8'hE7, 8'hCF, 8'h9F, 8'h3F, 8'hFC};
        test_reset(2);
        for (int k = 0; k < 8; k++) begin
            do_trigger(16'h00FF, 1, 1'b0, got);
            n_checks++;
            if (got !== {8'h00, tab[k]}) begin
                n_fail++;
                $display("FAIL rotation: row %0d got %h, required 00%h", k, got, tab[k]);
            end
            do_trigger(16'h00FF, 1, 1'b0, got);
        end
    endtask

    task automatic test_drop();
        logic [BW-1:0] got;
        test_reset(1);
        do_trigger(16'hFF0F, 3, 1'b1, got);
        do_trigger(16'h1234, 2, 1'b0, got);
        do_trigger(16'hF7F7, 3, 1'b1, got);
    endtask

    task automatic test_reset_mid_emit();
        logic [BW-1:0] got;
        test_reset(1);
        @(negedge clk);
        load_n  = 1'b0;
        data_in = BW'($urandom);
        @(negedge clk);
        data_in = 16'h00FF;
        load_n  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (strobe !== 1'b0 || dout !== 16'h00FC) begin
            n_fail++;
            $display("FAIL mid_emit: strobe=%b out=%h, required 0/00fc", strobe, dout);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (strobe !== 1'b1 || dout !== '0 || fix_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset: strobe=%b out=%h fc=%h, required 1/0000/0000",
                     strobe, dout, fix_count);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_trigger(16'h00FF, 1, 1'b0, got);
        n_checks++;
        if (got !== 16'h00FC) begin
            n_fail++;
            $display("FAIL after_reset_row: got %h, required 00fc", got);
        end
    endtask

    task automatic test_random();
        logic [BW-1:0] got;
        logic [BW-1:0] row;
        bit            rt;
        test_reset(2);
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 2))
                0:       row = BW'($urandom & $urandom);
                1:       row = BW'($urandom | $urandom | $urandom);
                default: row = BW'($urandom);
            endcase
            rt = (m_blanks == 0) && ($urandom_range(0, 3) == 0);
            do_trigger(row, $urandom_range(1, 3), rt, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        load_n   = 1'b1;
        data_in  = '0;
        model_reset();

        test_basic();
        test_hold_low();
        test_rotation();
        test_drop();
        test_reset_mid_emit();
        test_random();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
